// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war rope referee.
package tug_pkg;

  localparam int NPOS_DEF = 9;
  localparam int SCORE_W  = 3;

  typedef logic [$clog2(NPOS_DEF)-1:0] pos_t;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    OVER
  } ref_state_e;

  typedef enum logic {
    LEFT,
    RIGHT
  } side_e;

endpackage

// File: rtl/score_tally.sv
// Per-side point counter: counts one point per inc pulse, saturates at MAX_SCORE.
module score_tally
  import tug_pkg::*;
#(
  parameter int MAX_SCORE = 7
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               inc,
  output logic [SCORE_W-1:0] score,
  output logic               full
);

  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (inc && (score_q != MAX_S)) score_d = score_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score = score_q;
  assign full  = (score_q == MAX_S);

endmodule

// File: rtl/rope_referee.sv
// Tug-of-war referee: rope position, point/hold/match FSM, scores and LED field.
// Define PULL_LOCKOUT_EN to add a per-player dead time after each accepted pull.
module rope_referee
  import tug_pkg::*;
#(
  parameter int NPOS        = 9,
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 50000000,
  parameter int LOCKOUT_CYC = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               pullL,
  input  logic               pullR,
  output logic [NPOS-1:0]    lights,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               pointL,
  output logic               pointR,
  output logic               matchOver
);

  localparam int POS_W  = $clog2(NPOS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [POS_W-1:0]  CENTER    = POS_W'((NPOS - 1) / 2);
  localparam logic [POS_W-1:0]  LEFT_END  = POS_W'(NPOS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ref_state_e        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              point_l_q, point_l_d, point_r_q, point_r_d;
  logic              inc_l, inc_r, full_l, full_r;
  logic              acc_l, acc_r;
  logic              enter_hold;

`ifdef PULL_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [LOCK_W-1:0] LOCK_SET = LOCK_W'(LOCKOUT_CYC - 1);

  logic [LOCK_W-1:0] lock_l_q, lock_l_d, lock_r_q, lock_r_d;

  assign acc_l = pullL && (lock_l_q == '0);
  assign acc_r = pullR && (lock_r_q == '0);

  // The accepting cycle counts as the first dead cycle, hence LOCKOUT_CYC-1.
  always_comb begin
    lock_l_d = (lock_l_q != '0) ? lock_l_q - 1'b1 : lock_l_q;
    lock_r_d = (lock_r_q != '0) ? lock_r_q - 1'b1 : lock_r_q;
    if (enter_hold) begin
      lock_l_d = '0;
      lock_r_d = '0;
    end else if (state_q == PLAY) begin
      if (acc_l) lock_l_d = LOCK_SET;
      if (acc_r) lock_r_d = LOCK_SET;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lock_l_q <= '0;
      lock_r_q <= '0;
    end else begin
      lock_l_q <= lock_l_d;
      lock_r_q <= lock_r_d;
    end
  end
`else
  assign acc_l = pullL;
  assign acc_r = pullR;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    inc_l     = 1'b0;
    inc_r     = 1'b0;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    case (state_q)
      PLAY: begin
        if (acc_l && !acc_r) begin
          if (pos_q == LEFT_END) begin
            inc_l     = 1'b1;
            point_l_d = 1'b1;
            hold_d    = '0;
            state_d   = HOLD;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (acc_r && !acc_l) begin
          if (pos_q == '0) begin
            inc_r     = 1'b1;
            point_r_d = 1'b1;
            hold_d    = '0;
            state_d   = HOLD;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (full_l || full_r) begin
            state_d = OVER;
          end else begin
            pos_d   = CENTER;
            state_d = PLAY;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase
  end

  assign enter_hold = (state_q == PLAY) && (state_d == HOLD);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= PLAY;
      pos_q     <= CENTER;
      hold_q    <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hold_q    <= hold_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
    end
  end

  score_tally #(.MAX_SCORE(MAX_SCORE)) u_tally_l (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (inc_l),
    .score (scoreL),
    .full  (full_l)
  );

  score_tally #(.MAX_SCORE(MAX_SCORE)) u_tally_r (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (inc_r),
    .score (scoreR),
    .full  (full_r)
  );

  assign lights    = NPOS'(1) << pos_q;
  assign pointL    = point_l_q;
  assign pointR    = point_r_q;
  assign matchOver = (state_q == OVER);

endmodule
